// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the transmit frame sequencer.
package tx_seq_pkg;

  localparam int unsigned MOD_W  = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Smallest counter width that can hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// Memory read port plus MAC transmit FIFO write port, seen from the sequencer.
interface tx_frame_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  import tx_seq_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ff_tx_data;
  logic              ff_tx_wren;
  logic              ff_tx_rdy;
  logic              ff_tx_sop;
  logic              ff_tx_eop;
  logic [MOD_W-1:0]  ff_tx_mod;
  logic              ff_tx_err;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output ff_tx_data, ff_tx_wren, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err,
    input  ff_tx_rdy
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  ff_tx_data, ff_tx_wren, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err,
    output ff_tx_rdy
  );

endinterface

// File: rtl/tx_seq_gap_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module tx_seq_gap_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_sequencer.sv
// Reads a fixed-length frame from memory and streams it to the MAC TX FIFO.
// Optional TX_SEQ_ERR_INJECT_EN adds err_inject to flag a frame's eop word as errored.
module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned GAP_CYCLES  = 12,
  parameter int unsigned LAST_MOD    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        trig,
`ifdef TX_SEQ_ERR_INJECT_EN
  input  logic        err_inject,
`endif
  output logic        busy,
  output logic [15:0] frame_cnt,
  tx_frame_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);
  localparam int unsigned       GAP_W    = cnt_width(GAP_CYCLES);
  // Timer is loaded with GAP-1 so that done lands on the final gap cycle.
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                gap_load, gap_dec, gap_done;

  tx_seq_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .done     (gap_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef TX_SEQ_ERR_INJECT_EN
  logic err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && en && trig) err_d = err_inject;
  end
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    frame_cnt_d = frame_cnt_q;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && trig) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        state_d = SEND;
        hold_d  = bus.rd_data;
      end
      SEND: begin
        if (bus.ff_tx_rdy) begin
          if (idx_q == LAST_IDX) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            idx_d       = '0;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d  = GAP;
              gap_load = 1'b1;
            end
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    frame_cnt      = frame_cnt_q;
    bus.rd_en      = (state_q == FETCH);
    bus.rd_addr    = bus.rd_en ? idx_q : '0;
    bus.ff_tx_wren = (state_q == SEND);
    bus.ff_tx_data = bus.ff_tx_wren ? hold_q : '0;
    bus.ff_tx_sop  = bus.ff_tx_wren && (idx_q == '0);
    bus.ff_tx_eop  = bus.ff_tx_wren && (idx_q == LAST_IDX);
    bus.ff_tx_mod  = bus.ff_tx_eop ? MOD_W'(LAST_MOD) : '0;
`ifdef TX_SEQ_ERR_INJECT_EN
    bus.ff_tx_err  = bus.ff_tx_eop && err_q;
`else
    bus.ff_tx_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: a 4-word/gap-2 instance and a 1-word/gap-0 instance.
module tb_tx_frame_sequencer;

  localparam int FW_A = 4, GP_A = 2, LM_A = 3;
  localparam int FW_B = 1, GP_B = 0, LM_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, en_a, en_b, trig_a, trig_b, err_a, err_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  tx_frame_sequencer_if #(.ADDR_W(8)) bus_a ();
  tx_frame_sequencer_if #(.ADDR_W(8)) bus_b ();

  assign bus_a.rd_data = mem_a[bus_a.rd_addr];
  assign bus_b.rd_data = mem_b[bus_b.rd_addr];

  tx_frame_sequencer #(.FRAME_WORDS(FW_A), .ADDR_W(8), .GAP_CYCLES(GP_A), .LAST_MOD(LM_A)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .trig(trig_a),
`ifdef TX_SEQ_ERR_INJECT_EN
    .err_inject(err_a),
`endif
    .busy(busy_a), .frame_cnt(cnt_a), .bus(bus_a)
  );

  tx_frame_sequencer #(.FRAME_WORDS(FW_B), .ADDR_W(8), .GAP_CYCLES(GP_B), .LAST_MOD(LM_B)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .trig(trig_b),
`ifdef TX_SEQ_ERR_INJECT_EN
    .err_inject(err_b),
`endif
    .busy(busy_b), .frame_cnt(cnt_b), .bus(bus_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is a phase number p in 0..2N-1; even p fetches
  // word p/2, odd p offers word p/2 until accepted. g counts remaining gap cycles.
  int          ph   [2];
  int          g    [2];
  bit          merr [2];
  logic [15:0] fcnt [2];

  typedef struct {
    bit          en, trig, rdy;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [11];

  function automatic int fw(int i); return (i == 0) ? FW_A : FW_B; endfunction
  function automatic int gp(int i); return (i == 0) ? GP_A : GP_B; endfunction
  function automatic int lm(int i); return (i == 0) ? LM_A : LM_B; endfunction
  function automatic bit mbusy(int i); return (ph[i] >= 0) || (g[i] > 0); endfunction

  function automatic logic [63:0] pk(logic re, logic [7:0] ad, logic we, logic [31:0] d,
                                     logic s, logic e, logic [1:0] m, logic er, logic b,
                                     logic [15:0] c);
    return {re, ad, we, d, s, e, m, er, b, c};
  endfunction

  function automatic logic [63:0] expv(int i);
    logic re, we, s, e, er;
    logic [7:0]  ad;
    logic [31:0] d;
    logic [1:0]  m;
    re = (ph[i] >= 0) && (ph[i] % 2 == 0);
    we = (ph[i] >= 0) && (ph[i] % 2 == 1);
    ad = re ? 8'(ph[i] / 2) : 8'd0;
    d  = 32'd0;
    if (we) d = (i == 0) ? mem_a[ph[i] / 2] : mem_b[ph[i] / 2];
    s  = we && (ph[i] == 1);
    e  = we && (ph[i] == 2 * fw(i) - 1);
    m  = e ? 2'(lm(i)) : 2'd0;
`ifdef TX_SEQ_ERR_INJECT_EN
    er = e && merr[i];
`else
    er = 1'b0;
`endif
    return pk(re, ad, we, d, s, e, m, er, mbusy(i), fcnt[i]);
  endfunction

  function automatic logic [63:0] act(int i);
    if (i == 0)
      return pk(bus_a.rd_en, bus_a.rd_addr, bus_a.ff_tx_wren, bus_a.ff_tx_data, bus_a.ff_tx_sop,
                bus_a.ff_tx_eop, bus_a.ff_tx_mod, bus_a.ff_tx_err, busy_a, cnt_a);
    return pk(bus_b.rd_en, bus_b.rd_addr, bus_b.ff_tx_wren, bus_b.ff_tx_data, bus_b.ff_tx_sop,
              bus_b.ff_tx_eop, bus_b.ff_tx_mod, bus_b.ff_tx_err, busy_b, cnt_b);
  endfunction

  task automatic mreset(int i);
    ph[i] = -1; g[i] = 0; merr[i] = 1'b0; fcnt[i] = 16'd0;
  endtask

  task automatic mstep(int i, logic r, logic e, logic t, logic rdy, logic ev);
    if (!r) mreset(i);
    else if (ph[i] >= 0) begin
      if (ph[i] % 2 == 0) ph[i]++;
      else if (rdy) begin
        if (ph[i] == 2 * fw(i) - 1) begin
          fcnt[i] = fcnt[i] + 16'd1;
          ph[i]   = -1;
          g[i]    = gp(i);
        end else ph[i]++;
      end
    end else if (g[i] > 0) g[i]--;
    else if (e && t) begin
      ph[i]   = 0;
      merr[i] = ev;
    end
  endtask

  task automatic check(string name, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0, rst_a, en_a, trig_a, bus_a.ff_tx_rdy, err_a);
    mstep(1, rst_b, en_b, trig_b, bus_b.ff_tx_rdy, err_b);
    #1;
    check("a_cycle", act(0), expv(0));
    check("b_cycle", act(1), expv(1));
  endtask

  task automatic run_idle(int i);
    for (int k = 0; k < 80 && mbusy(i); k++) tick();
    check("idle_bound", {63'd0, (i == 0) ? busy_a : busy_b}, 64'd0);
  endtask

  initial begin
    logic [15:0] c0;
    int ec;

    rst_a = 0; rst_b = 0; en_a = 0; en_b = 0; trig_a = 0; trig_b = 0; err_a = 0; err_b = 0;
    bus_a.ff_tx_rdy = 1; bus_b.ff_tx_rdy = 1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hA0 + 32'(i);
      mem_b[i] = 32'hB0 + 32'(i);
    end
    mreset(0); mreset(1);
    tick(); tick();
    check("reset_a", act(0), 64'd0);
    check("reset_b", act(1), 64'd0);
    rst_a = 1; rst_b = 1;
    tick();

    tbl[0]  = '{1, 1, 1, pk(1, 0, 0, 0,     0, 0, 0, 0, 1, 0)};
    tbl[1]  = '{1, 0, 1, pk(0, 0, 1, 'hA0, 1, 0, 0, 0, 1, 0)};
    tbl[2]  = '{1, 0, 1, pk(1, 1, 0, 0,     0, 0, 0, 0, 1, 0)};
    tbl[3]  = '{1, 0, 1, pk(0, 0, 1, 'hA1, 0, 0, 0, 0, 1, 0)};
    tbl[4]  = '{1, 0, 1, pk(1, 2, 0, 0,     0, 0, 0, 0, 1, 0)};
    tbl[5]  = '{1, 0, 1, pk(0, 0, 1, 'hA2, 0, 0, 0, 0, 1, 0)};
    tbl[6]  = '{1, 0, 1, pk(1, 3, 0, 0,     0, 0, 0, 0, 1, 0)};
    tbl[7]  = '{1, 0, 1, pk(0, 0, 1, 'hA3, 0, 1, 3, 0, 1, 0)};
    tbl[8]  = '{1, 0, 1, pk(0, 0, 0, 0,     0, 0, 0, 0, 1, 1)};
    tbl[9]  = '{1, 0, 1, pk(0, 0, 0, 0,     0, 0, 0, 0, 1, 1)};
    tbl[10] = '{1, 0, 1, pk(0, 0, 0, 0,     0, 0, 0, 0, 0, 1)};
    for (int v = 0; v < 11; v++) begin
      en_a = tbl[v].en; trig_a = tbl[v].trig; bus_a.ff_tx_rdy = tbl[v].rdy;
      tick();
      check("table", act(0), tbl[v].exp);
    end

    // Backpressure on the second word.
    trig_a = 1; tick(); trig_a = 0;
    tick(); tick();
    bus_a.ff_tx_rdy = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("stall_hold", {29'd0, bus_a.ff_tx_wren, bus_a.ff_tx_data, bus_a.ff_tx_sop, bus_a.rd_en},
            {29'd0, 1'b1, 32'hA1, 1'b0, 1'b0});
    end
    bus_a.ff_tx_rdy = 1;
    tick();
    check("fetch_after", {55'd0, bus_a.rd_en, bus_a.rd_addr}, {55'd0, 1'b1, 8'd2});
    run_idle(0);

    // Trigger held through SEND and into GAP must not start a second frame.
    c0 = cnt_a;
    trig_a = 1;
    for (int k = 0; k < 9; k++) tick();
    trig_a = 0;
    run_idle(0);
    for (int k = 0; k < 4; k++) tick();
    check("one_frame", {48'd0, cnt_a}, {48'd0, c0 + 16'd1});

    // Single-word frame with no gap.
    en_b = 1; trig_b = 1; tick(); trig_b = 0;
    tick();
    check("single", {27'd0, bus_b.ff_tx_wren, bus_b.ff_tx_sop, bus_b.ff_tx_eop, bus_b.ff_tx_mod,
                     bus_b.ff_tx_data}, {27'd0, 1'b1, 1'b1, 1'b1, 2'd1, 32'hB0});
    tick();
    check("gap0", {47'd0, busy_b, cnt_b}, {47'd0, 1'b0, 16'd1});

    // Reset in the middle of the third word.
    trig_a = 1; tick(); trig_a = 0;
    for (int k = 0; k < 5; k++) tick();
    rst_a = 0;
    #1;
    check("rst_imm", act(0), 64'd0);
    mreset(0);
    tick(); tick();
    rst_a = 1;
    tick();
    trig_a = 1; tick(); trig_a = 0;
    tick();
    check("restart_sop", {31'd0, bus_a.ff_tx_sop, bus_a.ff_tx_data}, {31'd0, 1'b1, 32'hA0});
    run_idle(0);

`ifdef TX_SEQ_ERR_INJECT_EN
    err_a = 1; trig_a = 1; tick(); trig_a = 0; err_a = 0;
    ec = 0;
    for (int k = 0; k < 80 && mbusy(0); k++) begin
      tick();
      if (bus_a.ff_tx_err) ec++;
    end
    check("err_once", 64'(ec), 64'd1);
    trig_a = 1; tick(); trig_a = 0;
    ec = 0;
    for (int k = 0; k < 80 && mbusy(0); k++) begin
      tick();
      if (bus_a.ff_tx_err) ec++;
    end
    check("err_clear", 64'(ec), 64'd0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    for (int k = 0; k < 600; k++) begin
      en_a = ($urandom_range(0, 7) != 0); en_b = ($urandom_range(0, 7) != 0);
      trig_a = ($urandom_range(0, 3) == 0); trig_b = ($urandom_range(0, 3) == 0);
      bus_a.ff_tx_rdy = ($urandom_range(0, 3) != 0); bus_b.ff_tx_rdy = ($urandom_range(0, 3) != 0);
      err_a = 1'($urandom_range(0, 1)); err_b = 1'($urandom_range(0, 1));
      tick();
    end
    trig_a = 0; trig_b = 0; bus_a.ff_tx_rdy = 1; bus_b.ff_tx_rdy = 1;
    run_idle(0);
    run_idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
